// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel line-buffer controller.
package sobel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } lb_state_e;

  localparam int NUM_BANKS  = 3;
  localparam int LINE_CNT_W = 11;

  // One-hot bank select for a bank index 0..NUM_BANKS-1.
  function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [1:0] idx);
    return {{(NUM_BANKS-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Bank rotation 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] next_bank(input logic [1:0] idx);
    return (idx == 2'(NUM_BANKS - 1)) ? 2'd0 : 2'(idx + 2'd1);
  endfunction

endpackage

// File: rtl/sobel_col_cnt.sv
// Column counter for the line buffers. Counts active pixels of the current
// line, clears on the first idle cycle, and freezes at H_ACTIVE while
// flagging any further pixel as an overflow.
module sobel_col_cnt #(
  parameter int H_ACTIVE = 1920,
  parameter int CNT_W    = $clog2(H_ACTIVE + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             dv,
  output logic [CNT_W-1:0] col_cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(H_ACTIVE);

  assign ovf = dv & (col_cnt == LIMIT);

  // Pixel counter: frame start or idle clears, overflow holds.
  always_ff @(posedge clk) begin
    if (!rst) begin
      col_cnt <= '0;
    end else if (clr || !dv) begin
      col_cnt <= '0;
    end else if (!ovf) begin
      col_cnt <= col_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sobel_lb_ctrl.sv
// Line-buffer controller for a 3x3 Sobel window: rotates writes across three
// line banks, primes the window for two lines after each frame start, and
// delays syncs to match the one-cycle RAM read latency.
// Optional build macro SOBEL_LB_BORDER_BLANK_EN blanks win_valid_o on the
// first and last pixel of each line.
module sobel_lb_ctrl
  import sobel_pkg::*;
#(
  parameter int  COLORDEPTH = 8,
  parameter int  H_ACTIVE   = 1920,
  // One extra code so the address can sit at H_ACTIVE on overflow.
  localparam int ADDR_W     = $clog2(H_ACTIVE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dv_i,
  input  logic                  hs_i,
  input  logic                  vs_i,
  output logic [NUM_BANKS-1:0]  lb_we_o,
  output logic [ADDR_W-1:0]     lb_waddr_o,
  output logic [ADDR_W-1:0]     lb_raddr_o,
  output logic [1:0]            row_sel_o,
  output logic                  win_valid_o,
  output logic                  dv_o,
  output logic                  hs_o,
  output logic                  vs_o,
  output logic [LINE_CNT_W-1:0] line_cnt_o,
  output logic                  err_o
);

  if (COLORDEPTH < 1 || H_ACTIVE < 1) begin : g_bad_params
    $error("sobel_lb_ctrl: COLORDEPTH and H_ACTIVE must be positive");
  end

  lb_state_e             state;
  logic [1:0]            wr_ptr;
  logic [LINE_CNT_W-1:0] line_cnt;
  logic                  err;
  logic [ADDR_W-1:0]     col_cnt;
  logic                  ovf;
  logic                  dv_p1, hs_p1, vs_p1;
  logic [1:0]            row_sel_p1;
  logic                  vld_p1;
  logic                  win_vld_d;

  // Stage p0: input strobes and edge detection. Pixels are ignored in IDLE
  // so a line cut by reset is never written before the next frame start.
  logic vs_rise, active, dv_act, line_end;
  assign vs_rise  = vs_i & ~vs_p1;
  assign active   = (state != IDLE);
  assign dv_act   = dv_i & active;
  assign line_end = dv_p1 & ~dv_i & active;

  sobel_col_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .CNT_W    (ADDR_W)
  ) u_col_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (vs_rise),
    .dv      (dv_act),
    .col_cnt (col_cnt),
    .ovf     (ovf)
  );

  assign lb_we_o    = (dv_act & ~ovf) ? bank_onehot(wr_ptr) : '0;
  assign lb_waddr_o = col_cnt;
  assign lb_raddr_o = col_cnt;

`ifdef SOBEL_LB_BORDER_BLANK_EN
  assign win_vld_d = (state == RUN) & dv_i & (col_cnt != '0);
`else
  assign win_vld_d = (state == RUN) & dv_i;
`endif

  // Frame/line control: a frame start overrides a coincident line end.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      wr_ptr   <= 2'd0;
      line_cnt <= '0;
      err      <= 1'b0;
    end else if (vs_rise) begin
      state    <= PRIME;
      wr_ptr   <= 2'd0;
      line_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (ovf) begin
        err <= 1'b1;
      end
      if (line_end) begin
        wr_ptr <= next_bank(wr_ptr);
        if (line_cnt != {LINE_CNT_W{1'b1}}) begin
          line_cnt <= line_cnt + LINE_CNT_W'(1);
        end
        if (state == PRIME && line_cnt == LINE_CNT_W'(1)) begin
          state <= RUN;
        end
      end
    end
  end

  // Stage p1: align syncs, bank index and window valid with RAM read data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dv_p1      <= 1'b0;
      hs_p1      <= 1'b0;
      vs_p1      <= 1'b0;
      row_sel_p1 <= 2'd0;
      vld_p1     <= 1'b0;
    end else begin
      dv_p1      <= dv_i;
      hs_p1      <= hs_i;
      vs_p1      <= vs_i;
      row_sel_p1 <= wr_ptr;
      vld_p1     <= win_vld_d;
    end
  end

  assign dv_o       = dv_p1;
  assign hs_o       = hs_p1;
  assign vs_o       = vs_p1;
  assign row_sel_o  = row_sel_p1;
  assign line_cnt_o = line_cnt;
  assign err_o      = err;

`ifdef SOBEL_LB_BORDER_BLANK_EN
  // The last pixel of a line surfaces in the cycle dv_i drops, so gating
  // with the live strobe removes exactly that column.
  assign win_valid_o = vld_p1 & dv_i;
`else
  assign win_valid_o = vld_p1;
`endif

endmodule
